i2c_txn_arbiter: RTL and testbench

//  Shares one i2c_controller between NUM_REQ requesters. Round-robin arbitrates pending

---
 rtl/i2c_txn_arbiter_if.sv | 38 +++
 rtl/i2c_txn_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side and controller-side signals of the I2C transaction arbiter.
// master = arbiter, slave = requesters plus the i2c_controller.
interface i2c_txn_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*8-1:0]     req_addr;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ*8-1:0]     req_wdata;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       wdata_pop;
  logic [7:0]               rdata;
  logic [NUM_REQ-1:0]       rdata_valid;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       error;
  logic                     ctrl_enable;
  logic [7:0]               ctrl_slave_address;
  logic [7:0]               ctrl_data_in;
  logic                     ctrl_idle;
  logic                     ctrl_byte_done;
  logic                     ctrl_nack;
  logic [7:0]               ctrl_rdata;

  modport master (
    input  req, req_addr, req_len, req_wdata,
           ctrl_idle, ctrl_byte_done, ctrl_nack, ctrl_rdata,
    output grant, wdata_pop, rdata, rdata_valid, done, error,
           ctrl_enable, ctrl_slave_address, ctrl_data_in
  );

  modport slave (
    output req, req_addr, req_len, req_wdata,
           ctrl_idle, ctrl_byte_done, ctrl_nack, ctrl_rdata,
    input  grant, wdata_pop, rdata, rdata_valid, done, error,
           ctrl_enable, ctrl_slave_address, ctrl_data_in
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between NUM_REQ requesters.
// Optional byte-progress watchdog: define I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               i2c_clk,
  input  logic               rst_n,
  i2c_txn_arbiter_if.master  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LAUNCH,
    S_XFER,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr;
  logic [IDX_W-1:0]   r_owner;
  logic [7:0]         r_addr;
  logic [LEN_W-1:0]   r_remaining;
  logic               r_err;
  logic               r_enable;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_rdata_valid;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] r_error;
  logic [7:0]         r_rdata;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]    r_to_cnt;
`else
  logic               w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [7:0]         w_pick_addr;
  logic [LEN_W-1:0]   w_pick_len;
  logic [LEN_W-1:0]   w_rem_next;
  logic               w_byte_ok;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  // Scan offsets from the far end so the closest request at/after r_rr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_pick_valid = 1'b0;
    w_pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(r_rr) + k) % NUM_REQ;
      if (bus.req[j]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = IDX_W'(j);
      end
    end
  end

  assign w_pick_addr = bus.req_addr[{w_pick_idx, 3'b000} +: 8];
  assign w_pick_len  = bus.req_len[int'(w_pick_idx) * LEN_W +: LEN_W];
  assign w_rem_next  = r_remaining - 1'b1;

  // A NACK in the same cycle as byte_done voids the byte.
  assign w_byte_ok = (r_state == S_XFER) && bus.ctrl_byte_done && !bus.ctrl_nack;

  assign bus.grant              = r_grant;
  assign bus.wdata_pop          = (w_byte_ok && !r_addr[0]) ? r_grant : '0;
  assign bus.rdata              = r_rdata;
  assign bus.rdata_valid        = r_rdata_valid;
  assign bus.done               = r_done;
  assign bus.error              = r_error;
  assign bus.ctrl_enable        = r_enable;
  assign bus.ctrl_slave_address = r_addr;
  assign bus.ctrl_data_in       = (|r_grant) ? bus.req_wdata[{r_owner, 3'b000} +: 8] : 8'h00;

  // NOTE: state is async-reset and updated only with non-blocking assignments.
  always_ff @(posedge i2c_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rr          <= '0;
      r_owner       <= '0;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_err         <= 1'b0;
      r_enable      <= 1'b0;
      r_grant       <= '0;
      r_rdata_valid <= '0;
      r_done        <= '0;
      r_error       <= '0;
      r_rdata       <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      r_to_cnt      <= '0;
`endif
    end else begin
      r_done        <= '0;
      r_error       <= '0;
      r_rdata_valid <= '0;

      case (r_state)
        S_IDLE: begin
          if (bus.ctrl_idle && (|bus.req)) r_state <= S_ARB;
        end

        S_ARB: begin
          if (!w_pick_valid) begin
            r_state <= S_IDLE;
          end else begin
            r_owner <= w_pick_idx;
            r_addr  <= w_pick_addr;
            if (w_pick_len == '0) begin
              r_error <= onehot(w_pick_idx);
              r_rr    <= next_idx(w_pick_idx);
              r_state <= S_IDLE;
            end else begin
              r_grant     <= onehot(w_pick_idx);
              r_remaining <= w_pick_len;
              r_err       <= 1'b0;
              r_enable    <= 1'b1;
              r_state     <= S_LAUNCH;
            end
          end
        end

        S_LAUNCH: begin
          if (!bus.ctrl_idle) begin
            r_enable <= (r_remaining > LEN_W'(1));
            r_state  <= S_XFER;
          end
        end

        S_XFER: begin
          if (bus.ctrl_nack) begin
            r_err    <= 1'b1;
            r_enable <= 1'b0;
            r_state  <= S_DRAIN;
          end else if (bus.ctrl_byte_done) begin
            r_remaining <= w_rem_next;
            // Enable falls while the last byte is in flight so the master sends STOP.
            r_enable    <= (w_rem_next > LEN_W'(1));
            if (r_addr[0]) begin
              r_rdata       <= bus.ctrl_rdata;
              r_rdata_valid <= r_grant;
            end
            if (w_rem_next == '0) r_state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          r_enable <= 1'b0;
          if (bus.ctrl_idle) begin
            if (r_err) r_error <= r_grant;
            else       r_done  <= r_grant;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_grant     <= '0;
          r_remaining <= '0;
          r_err       <= 1'b0;
          r_rr        <= next_idx(r_owner);
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase

`ifdef I2C_ARB_TIMEOUT_EN
      // Watchdog overrides the FSM; it does not wait for the controller to go idle.
      if (r_state == S_ARB) begin
        r_to_cnt <= '0;
      end else if (r_state == S_LAUNCH || r_state == S_XFER || r_state == S_DRAIN) begin
        if (r_state == S_XFER && bus.ctrl_byte_done) begin
          r_to_cnt <= '0;
        end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          r_to_cnt    <= '0;
          r_enable    <= 1'b0;
          r_done      <= '0;
          r_error     <= r_grant;
          r_grant     <= '0;
          r_remaining <= '0;
          r_err       <= 1'b0;
          r_rr        <= next_idx(r_owner);
          r_state     <= S_IDLE;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter with a behavioural i2c_controller model.
// Exercises the watchdog as well when built with I2C_ARB_TIMEOUT_EN.
module tb_i2c_txn_arbiter;

  localparam int NR = 4;
  localparam int K_NONE = 0, K_POP = 1, K_RDV = 2, K_DONE = 3, K_ERR = 4;

  typedef struct {
    int kind;
    int idx;
    int data;
  } ev_t;

  logic i2c_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 i2c_clk = ~i2c_clk;

  i2c_txn_arbiter_if #(.NUM_REQ(NR), .LEN_W(8)) bus ();

  i2c_txn_arbiter #(.NUM_REQ(NR), .LEN_W(8), .TIMEOUT_CYCLES(16)) dut (
    .i2c_clk (i2c_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  ev_t        sq[$];
  int         gq[$];
  logic [7:0] rd_q[$];
  logic [7:0] rd_pre[$];

  int   t_len  [NR];
  logic [7:0] t_addr [NR];
  int   w_cnt  [NR];
  int   e_cnt  [NR];

  int   ctl_nack_at = -1;
  bit   ctl_both    = 1'b0;
  bit   ctl_stall   = 1'b0;
  bit   seen_grant  = 1'b0;
  bit   seen_en     = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] wbyte(input int i, input int n);
    return 8'(i * 64 + n * 7 + 3);
  endfunction

  always_comb begin
    bus.req_wdata = '0;
    for (int i = 0; i < NR; i++) bus.req_wdata[i*8 +: 8] = wbyte(i, w_cnt[i]);
  end

  // Controller model: launches when enabled, one byte every 4 cycles, STOP when
  // enable is already low as a byte starts.
  int c_byte;
  bit c_stop;
  bit c_last;
  initial begin
    bus.ctrl_idle      = 1'b1;
    bus.ctrl_byte_done = 1'b0;
    bus.ctrl_nack      = 1'b0;
    bus.ctrl_rdata     = 8'h00;
    forever begin
      @(posedge i2c_clk); #1;
      if (bus.ctrl_enable && bus.ctrl_idle) begin
        repeat (2) @(posedge i2c_clk);
        #1 bus.ctrl_idle = 1'b0;
        c_byte = 0;
        c_stop = 1'b0;
        while (!c_stop) begin
          if (ctl_stall) begin
            while (ctl_stall) @(posedge i2c_clk);
            c_stop = 1'b1;
          end else begin
            repeat (3) @(posedge i2c_clk);
            #1;
            c_last = !bus.ctrl_enable;
            if (c_byte == ctl_nack_at) begin
              bus.ctrl_nack      = 1'b1;
              bus.ctrl_byte_done = ctl_both;
              bus.ctrl_rdata     = 8'hEE;
              c_stop = 1'b1;
            end else begin
              bus.ctrl_byte_done = 1'b1;
              bus.ctrl_rdata     = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hEE;
              c_stop = c_last;
            end
            c_byte++;
            @(posedge i2c_clk);
            #1;
            bus.ctrl_byte_done = 1'b0;
            bus.ctrl_nack      = 1'b0;
          end
        end
        repeat (2) @(posedge i2c_clk);
        #1 bus.ctrl_idle = 1'b1;
      end
    end
  end

  task automatic compare_ev(input int kind, input int idx, input int data);
    ev_t e;
    if (sq.size() != 0) e = sq.pop_front();
    else                e = '{K_NONE, -1, 0};
    check("ev_kind", kind, e.kind);
    check("ev_idx",  idx,  e.idx);
    check("ev_data", data, e.data);
  endtask

  // Monitor: samples on the falling edge and consumes the scoreboard.
  logic [NR-1:0] prev_grant = '0;
  int  cur_len = 0;
  int  cur_k   = 0;
  bit  chk_en0 = 1'b0;
  initial begin
    for (int i = 0; i < NR; i++) w_cnt[i] = 0;
    forever begin
      @(negedge i2c_clk);
      if (!rst_n) begin
        prev_grant = '0;
        chk_en0    = 1'b0;
      end else begin
        seen_grant = seen_grant | (|bus.grant);
        seen_en    = seen_en | bus.ctrl_enable;
        if (bus.grant != '0 && prev_grant == '0) begin
          int eg;
          eg = (gq.size() != 0) ? gq.pop_front() : -1;
          check("grant", 32'(bus.grant), (eg < 0) ? 32'h0 : (32'h1 << eg));
          if (eg >= 0) begin
            check("slave_addr", 32'(bus.ctrl_slave_address), 32'(t_addr[eg]));
            cur_len = t_len[eg];
          end
          cur_k = 0;
        end
        prev_grant = bus.grant;
        if (chk_en0) begin
          check("en_after_nack", 32'(bus.ctrl_enable), 0);
          chk_en0 = 1'b0;
        end
        if (bus.ctrl_nack) begin
          chk_en0 = 1'b1;
        end else if (bus.ctrl_byte_done && bus.grant != '0) begin
          check("en_at_byte", 32'(bus.ctrl_enable), 32'((cur_len - cur_k) > 1));
          cur_k++;
        end
        for (int i = 0; i < NR; i++) begin
          if (bus.wdata_pop[i]) begin
            compare_ev(K_POP, i, int'(bus.ctrl_data_in));
            w_cnt[i]++;
          end
          if (bus.rdata_valid[i]) compare_ev(K_RDV, i, int'(bus.rdata));
          if (bus.done[i])        compare_ev(K_DONE, i, 0);
          if (bus.error[i])       compare_ev(K_ERR, i, 0);
        end
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sq.size() != 0 || gq.size() != 0 || !bus.ctrl_idle || bus.grant != '0) && n < 300) begin
      @(negedge i2c_clk);
      n++;
    end
    check(tag, sq.size() + gq.size(), 0);
    repeat (3) @(negedge i2c_clk);
  endtask

  task automatic set_req(input int idx, input logic [7:0] addr, input int len);
    t_addr[idx] = addr;
    t_len[idx]  = len;
    bus.req_addr[idx*8 +: 8] = addr;
    bus.req_len[idx*8 +: 8]  = 8'(len);
  endtask

  task automatic run_txn(input string tag, input int idx, input logic [7:0] addr,
                         input int len, input int nack_at, input bit both);
    int nb;
    bit ok;
    logic [7:0] d;
    set_req(idx, addr, len);
    ctl_nack_at = nack_at;
    ctl_both    = both;
    if (len == 0) begin
      sq.push_back('{K_ERR, idx, 0});
    end else begin
      gq.push_back(idx);
      nb = (nack_at >= 0 && nack_at < len) ? nack_at : len;
      for (int b = 0; b < nb; b++) begin
        if (addr[0]) begin
          d = (rd_pre.size() != 0) ? rd_pre.pop_front() : 8'($urandom);
          rd_q.push_back(d);
          sq.push_back('{K_RDV, idx, int'(d)});
        end else begin
          sq.push_back('{K_POP, idx, int'(wbyte(idx, e_cnt[idx]))});
          e_cnt[idx]++;
        end
      end
      sq.push_back('{(nb < len) ? K_ERR : K_DONE, idx, 0});
    end
    bus.req[idx] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge i2c_clk);
      ok = bus.done[idx] | bus.error[idx];
    end
    bus.req[idx] = 1'b0;
    check({tag, "_wait"}, 32'(ok), 1);
    drain({tag, "_drain"});
  endtask

  initial begin
    int cnt;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_len  = '0;
    for (int i = 0; i < NR; i++) begin
      e_cnt[i]  = 0;
      t_len[i]  = 0;
      t_addr[i] = 8'h00;
    end

    repeat (3) @(negedge i2c_clk);
    check("rst_grant",   32'(bus.grant), 0);
    check("rst_enable",  32'(bus.ctrl_enable), 0);
    check("rst_addr",    32'(bus.ctrl_slave_address), 0);
    check("rst_din",     32'(bus.ctrl_data_in), 0);
    check("rst_done",    32'(bus.done), 0);
    check("rst_error",   32'(bus.error), 0);
    check("rst_rvalid",  32'(bus.rdata_valid), 0);
    check("rst_pop",     32'(bus.wdata_pop), 0);
    check("rst_rdata",   32'(bus.rdata), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge i2c_clk);

    // Fairness with every requester permanently requesting one-byte writes.
    ctl_nack_at = -1;
    ctl_both    = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 8'(8'h50 + 2 * i), 1);
    for (int r = 0; r < 5; r++) begin
      int o;
      o = r % NR;
      gq.push_back(o);
      sq.push_back('{K_POP, o, int'(wbyte(o, e_cnt[o]))});
      e_cnt[o]++;
      sq.push_back('{K_DONE, o, 0});
    end
    bus.req = '1;
    cnt = 0;
    for (int n = 0; n < 2000 && cnt < 5; n++) begin
      @(negedge i2c_clk);
      if (|bus.done) cnt++;
    end
    bus.req = '0;
    check("fair_done_count", cnt, 5);
    drain("fair_drain");

    run_txn("write3", 1, 8'hA0, 3, -1, 1'b0);
    rd_pre.push_back(8'h5A);
    rd_pre.push_back(8'hC3);
    run_txn("read2", 0, 8'hA1, 2, -1, 1'b0);
    run_txn("nack", 3, 8'h3C, 4, 2, 1'b0);
    run_txn("nack_both", 2, 8'h6B, 3, 0, 1'b1);

    seen_grant = 1'b0;
    seen_en    = 1'b0;
    run_txn("len0", 2, 8'h22, 0, -1, 1'b0);
    check("len0_no_grant",  32'(seen_grant), 0);
    check("len0_no_enable", 32'(seen_en), 0);

    run_txn("write1", 3, 8'h90, 1, -1, 1'b0);
    for (int t = 0; t < 4; t++) begin
      int   ri;
      logic rw;
      ri = int'($urandom_range(0, NR - 1));
      rw = 1'($urandom_range(0, 1));
      run_txn("rand", ri, {7'($urandom), rw}, int'($urandom_range(1, 5)), -1, 1'b0);
    end

`ifdef I2C_ARB_TIMEOUT_EN
    begin
      int lat;
      int n;
      ctl_stall = 1'b1;
      set_req(2, 8'hB4, 3);
      gq.push_back(2);
      sq.push_back('{K_ERR, 2, 0});
      bus.req[2] = 1'b1;
      n = 0;
      while (!bus.ctrl_enable && n < 100) begin
        @(negedge i2c_clk);
        n++;
      end
      lat = 0;
      while (!bus.error[2] && lat < 100) begin
        @(negedge i2c_clk);
        lat++;
      end
      check("timeout_latency", lat, 16);
      bus.req[2] = 1'b0;
      ctl_stall  = 1'b0;
      drain("timeout_drain");
    end
`endif

    // Reset in the middle of a 5-byte write: no completion may follow.
    ctl_nack_at = -1;
    set_req(1, 8'h44, 5);
    gq.push_back(1);
    sq.push_back('{K_POP, 1, int'(wbyte(1, e_cnt[1]))});
    e_cnt[1]++;
    bus.req[1] = 1'b1;
    cnt = 0;
    for (int n = 0; n < 300 && cnt == 0; n++) begin
      @(negedge i2c_clk);
      if (bus.wdata_pop[1]) cnt = 1;
    end
    check("mid_first_pop", cnt, 1);
    @(posedge i2c_clk);
    #2;
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    check("mid_rst_grant",  32'(bus.grant), 0);
    check("mid_rst_enable", 32'(bus.ctrl_enable), 0);
    sq.delete();
    gq.delete();
    repeat (3) @(negedge i2c_clk);
    rst_n = 1'b1;
    repeat (60) @(negedge i2c_clk);
    check("mid_post_grant", 32'(bus.grant), 0);
    check("mid_post_sb",    sq.size() + gq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
